// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Byte-enable, store-lane replication and load extraction live here so the top stays FSM-only.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_e;

  function automatic logic [3:0] byte_en(size_e sz, logic [1:0] lane);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the low bits of store data across every lane; byte enables pick the live ones.
  function automatic logic [WORD_W-1:0] store_lanes(logic [WORD_W-1:0] wdat, size_e sz);
    logic [WORD_W-1:0] r;
    case (sz)
      SZ_BYTE: r = {4{wdat[7:0]}};
      SZ_HALF: r = {2{wdat[15:0]}};
      default: r = wdat;
    endcase
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] load_extract(logic [WORD_W-1:0] word, size_e sz,
                                                     logic [1:0] lane, logic sext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [WORD_W-1:0]  r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: r = sext ? WORD_W'(b) : {24'b0, b};
      SZ_HALF: r = sext ? WORD_W'(h) : {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enable and combinational read.
// Contents are deliberately left uninitialised and untouched by reset.
module dmem_array #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [3:0]               we,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: captures one request, waits WAIT_CYCLES in ACCESS,
// commits or reads the word, then pulses Ready for one cycle in RESP.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] Addr,
  input  logic [AWIDTH-1:0] WrDat,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [1:0]        Size,
  input  logic              SignExt,
  output logic [AWIDTH-1:0] ReaDat,
  output logic              Ready,
  output logic              Busy,
  output logic              AlignErr
);

  localparam int IW = $clog2(DEPTH);

  state_e            state;
  logic [3:0]        cnt;
  logic              req;
  logic              req_err;
  size_e             size_in;

  logic [IW-1:0]     idx_q;
  logic [1:0]        lane_q;
  size_e             size_q;
  logic              sext_q;
  logic              wr_q;
  logic              err_q;
  logic [AWIDTH-1:0] wdat_q;

  logic [3:0]        we;
  logic [31:0]       rdata;
  logic              do_access;
  logic              unused_addr;

  // Address bits above the word index alias onto the same array entry.
  assign unused_addr = ^Addr[AWIDTH-1:IW+2];

  assign req     = MemRd | MemWr;
  assign size_in = size_e'(Size);
  assign req_err = (MemRd & MemWr)
                 | (size_in == SZ_BAD)
                 | ((size_in == SZ_HALF) & Addr[0])
                 | ((size_in == SZ_WORD) & (Addr[1:0] != 2'b00));

  assign do_access = (state == S_ACCESS) && (cnt == 4'd0);
  assign we        = (do_access && wr_q && !err_q) ? byte_en(size_q, lane_q) : 4'b0000;

  // Request capture: data-only registers, loaded only when IDLE accepts.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      idx_q  <= Addr[IW+1:2];
      lane_q <= Addr[1:0];
      size_q <= size_in;
      sext_q <= SignExt;
      wr_q   <= MemWr & ~MemRd;
      err_q  <= req_err;
      wdat_q <= WrDat;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .idx   (idx_q),
    .we    (we),
    .wdata (store_lanes(wdat_q, size_q)),
    .rdata (rdata)
  );

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      Ready    <= 1'b0;
      Busy     <= 1'b0;
      AlignErr <= 1'b0;
      ReaDat   <= '0;
    end else begin
      Ready    <= 1'b0;
      AlignErr <= 1'b0;
      ReaDat   <= '0;
      case (state)
        S_IDLE: begin
          if (req) begin
            state <= S_ACCESS;
            cnt   <= 4'(WAIT_CYCLES);
            Busy  <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            state    <= S_RESP;
            Ready    <= 1'b1;
            AlignErr <= err_q;
            if (!err_q && !wr_q) ReaDat <= load_extract(rdata, size_q, lane_q, sext_q);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: byte-addressed reference memory,
// expectations queued at issue time and checked by a Ready-driven monitor.
module tb_data_mem_responder;

  localparam int AW    = 32;
  localparam int DEPTH = 256;
  localparam int W     = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] Addr = '0;
  logic [AW-1:0] WrDat = '0;
  logic          MemRd = 1'b0;
  logic          MemWr = 1'b0;
  logic [1:0]    Size = 2'b00;
  logic          SignExt = 1'b0;
  logic [AW-1:0] ReaDat;
  logic          Ready;
  logic          Busy;
  logic          AlignErr;

  data_mem_responder #(
    .AWIDTH      (AW),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Addr     (Addr),
    .WrDat    (WrDat),
    .MemRd    (MemRd),
    .MemWr    (MemWr),
    .Size     (Size),
    .SignExt  (SignExt),
    .ReaDat   (ReaDat),
    .Ready    (Ready),
    .Busy     (Busy),
    .AlignErr (AlignErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [7:0]  mref [0:4*DEPTH-1];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          readies = 0;
  int          issued = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference: byte array, aligned accesses, arithmetic extension.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                                 input logic wr, input logic [1:0] sz, input logic sx);
    exp_t        r;
    int          base;
    int          nb;
    logic [31:0] v;
    base  = int'(a[9:0]);
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    r.dat = 32'h0;
    r.err = (rd && wr) || (sz == 2'd3) || ((int'(a[1:0]) % nb) != 0);
    r.cyc = 0;
    r.name = "";
    if (!r.err) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) mref[base + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(mref[base + i]) << (8 * i));
        if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        r.dat = v;
      end
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (Ready) begin
      readies++;
      if (q.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk({mon_e.name, "_data"}, ReaDat, mon_e.dat);
        chk({mon_e.name, "_alignerr"}, 32'(AlignErr), 32'(mon_e.err));
        chk({mon_e.name, "_latency"}, cyc - mon_e.cyc, W + 2);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic sx, input string name,
                       input logic use_exp, input logic [31:0] xd, input logic xe);
    exp_t e;
    @(negedge clk);
    Addr = a; WrDat = wd; MemRd = rd; MemWr = wr; Size = sz; SignExt = sx;
    e = model(a, wd, rd, wr, sz, sx);
    if (use_exp) begin
      e.dat = xd;
      e.err = xe;
    end
    e.cyc  = cyc;
    e.name = name;
    q.push_back(e);
    issued++;
    @(negedge clk);
    chk({name, "_busy"}, 32'(Busy), 32'd1);
    MemRd = 1'b0; MemWr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (Busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout busy=%0b required=0", Busy);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr,
                     input logic [1:0] sz, input logic sx, input string name,
                     input logic use_exp, input logic [31:0] xd, input logic xe);
    issue(a, wd, rd, wr, sz, sx, name, use_exp, xd, xe);
    wait_idle();
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          op;
    int          n;

    repeat (2) @(negedge clk);
    chk("reset_readat", ReaDat, 32'h0);
    chk("reset_ready", 32'(Ready), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_alignerr", 32'(AlignErr), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      req(32'(i * 4), $urandom, 1'b0, 1'b1, 2'd2, 1'b0, "init", 1'b0, 32'h0, 1'b0);

    req(32'h4, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd2, 1'b0, "st_word", 1'b1, 32'h0, 1'b0);
    req(32'h4, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, "ld_word", 1'b1, 32'hDEAD_BEEF, 1'b0);
    req(32'h6, 32'h0000_00AA, 1'b0, 1'b1, 2'd0, 1'b0, "st_byte", 1'b1, 32'h0, 1'b0);
    req(32'h4, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, "ld_merged", 1'b1, 32'hDEAA_BEEF, 1'b0);
    req(32'h6, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, "ld_byte_sx", 1'b1, 32'hFFFF_FFAA, 1'b0);
    req(32'h6, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, "ld_byte_zx", 1'b1, 32'h0000_00AA, 1'b0);
    req(32'h5, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, "ld_half_mis", 1'b1, 32'h0, 1'b1);
    req(32'h6, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, "ld_word_mis", 1'b1, 32'h0, 1'b1);
    req(32'h5, 32'h0000_1234, 1'b0, 1'b1, 2'd1, 1'b0, "st_half_mis", 1'b1, 32'h0, 1'b1);
    req(32'h4, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, "ld_after_err", 1'b1, 32'hDEAA_BEEF, 1'b0);
    req(32'h4, 32'h0, 1'b1, 1'b0, 2'd3, 1'b0, "size_bad", 1'b1, 32'h0, 1'b1);
    req(32'h0000_0400, 32'h1234_5678, 1'b0, 1'b1, 2'd2, 1'b0, "st_wrap", 1'b1, 32'h0, 1'b0);
    req(32'h0, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, "ld_wrap", 1'b1, 32'h1234_5678, 1'b0);

    // Second store held through ACCESS and RESP must be dropped.
    issue(32'hC, 32'h1111_2222, 1'b0, 1'b1, 2'd2, 1'b0, "busy_first", 1'b1, 32'h0, 1'b0);
    Addr = 32'h10; WrDat = 32'h3333_4444; MemWr = 1'b1; Size = 2'd2;
    n = 0;
    while (!Ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_ready_seen", 32'(Ready), 32'd1);
    MemWr = 1'b0;
    wait_idle();
    req(32'hC, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, "busy_ld_first", 1'b1, 32'h1111_2222, 1'b0);
    req(32'h10, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, "busy_ld_second", 1'b0, 32'h0, 1'b0);

    req(32'h14, 32'h0000_0055, 1'b1, 1'b1, 2'd2, 1'b0, "rdwr_both", 1'b1, 32'h0, 1'b1);
    req(32'h14, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, "rdwr_ld", 1'b0, 32'h0, 1'b0);

    // Reset lands while the store at 0x8 is still counting down.
    @(negedge clk);
    Addr = 32'h8; WrDat = 32'hFFFF_FFFF; MemWr = 1'b1; Size = 2'd2; SignExt = 1'b0;
    @(negedge clk);
    MemWr = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(Ready), 32'd0);
    chk("rst_mid_busy", 32'(Busy), 32'd0);
    chk("rst_mid_alignerr", 32'(AlignErr), 32'd0);
    chk("rst_mid_readat", ReaDat, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_after_busy", 32'(Busy), 32'd0);
    req(32'h8, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, "rst_ld_prior", 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      a  = 32'($urandom_range(0, 2047));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      op = $urandom_range(0, 9);
      req(a, $urandom, (op == 0) || (op > 4), (op <= 4), sz, 1'($urandom_range(0, 1)),
          "rand", 1'b0, 32'h0, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("drain_queue", 32'(q.size()), 32'd0);
    chk("ready_count", 32'(readies), 32'(issued));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the 32-bit processor's load/store path.
- Produces the ReaDat word that the write-back 2:1 select steers onto WD when MS2=1.
- Accepts one load or store request at a time from the execute stage. It handles it through a small FSM with configurable access latency.
- Supports byte/half/word access with sign/zero extension, and flags misaligned requests.

Parameters:
AWIDTH, 32, address and data width
DEPTH, 256, memory depth in 32-bit words (power of 2)
WAIT_CYCLES, 1, extra cycles spent in ACCESS before response (0..15)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
Addr  input  AWIDTH  byte address of request
WrDat  input  AWIDTH  store data, lane-aligned in low bits
MemRd  input  1  load request
MemWr  input  1  store request
Size  input  2  00 byte, 01 half, 10 word, 11 illegal
SignExt  input  1  1 sign-extend loads, 0 zero-extend
ReaDat  output  AWIDTH  load result, valid while Ready=1
Ready  output  1  one-cycle response pulse
Busy  output  1  high while a request is in flight
AlignErr  output  1  asserted with Ready when the request was rejected

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; ReaDat=0, Ready=0, Busy=0, AlignErr=0; wait counter=0.
  - Memory array is not cleared.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On a clk edge with MemRd|MemWr=1, capture Addr, WrDat, Size, SignExt and op; set Busy=1 the next cycle.
  - Go to ACCESS with counter=WAIT_CYCLES.
- ACCESS:
  - Counter decrements each cycle. At 0: perform the access, then go to RESP.
  - Minimum latency from request edge to Ready is WAIT_CYCLES+2 cycles.
- RESP:
  - Ready=1 for exactly one cycle, with ReaDat/AlignErr valid.
  - Go to IDLE; Busy drops the same edge.
  - Requests presented while Busy=1 or during RESP are ignored; the requester holds them until IDLE.
- Address decode:
  - Word index = Addr[log2(DEPTH)+1:2]; upper bits are ignored (wrap-around aliasing).
  - Lane = Addr[1:0], little-endian.
- Loads:
  - Byte: select lane Addr[1:0].
  - Half: select lane pair Addr[1].
  - Word: whole word.
  - Extend to 32 bits per SignExt; SignExt is ignored for word loads.
- Stores:
  - Read-modify-write of the addressed word; only the byte-enabled lanes change.
  - Byte: WrDat[7:0] goes to lane Addr[1:0]. Half: WrDat[15:0] goes to lane pair Addr[1].
  - Write commits on the ACCESS->RESP edge. ReaDat=0 on stores.
- Errors set AlignErr=1 with Ready; no memory update; ReaDat=0. Error cases:
  - half with Addr[0]=1
  - word with Addr[1:0]!=0
  - Size=11
  - MemRd and MemWr both 1 in the same cycle
- Reset mid-operation: request is abandoned and an uncommitted store is lost. No Ready is emitted after reset release.
- A store followed by a load to the same address returns the new data; no forwarding is needed because accesses are serialised.

Decomposition:
- Shared package dmem_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD)
  - FSM state enum (S_IDLE, S_ACCESS, S_RESP)
  - function computing the byte-enable mask from size/lane
  - function for load extraction and extension
- One sub-module, dmem_array: single-port word RAM, DEPTH x 32, with 4-bit byte write enable and combinational read.
- Top level holds the FSM, capture registers, alignment check and lane logic.

Test Plan:
- Reset, then word store Addr=0x00000004, WrDat=0xDEADBEEF, then word load 0x4 -> Ready after WAIT_CYCLES+2 cycles, ReaDat=0xDEADBEEF, AlignErr=0.
- Byte store 0xAA at Addr=0x6 over 0xDEADBEEF -> word load 0x4 gives 0xDEAABEEF. Byte load 0x6 with SignExt=1 -> 0xFFFFFFAA; with SignExt=0 -> 0x000000AA.
- Half load Addr=0x5, then word load Addr=0x6 -> each returns Ready with AlignErr=1, ReaDat=0. Memory at 0x4 is unchanged (still 0xDEAABEEF).
- Wrap-around: store 0x12345678 to Addr=0x00000400 (DEPTH=256) -> load Addr=0x0 returns 0x12345678.
- Second request asserted while Busy=1 -> ignored: only one Ready pulse, and memory reflects the first request only. MemRd=MemWr=1 -> AlignErr=1, no write.
- Store to 0x8 of 0xFFFFFFFF, rst_n pulsed low during ACCESS (WAIT_CYCLES=3) -> outputs 0 immediately, no Ready after release. A later load of 0x8 returns the prior contents.
